vga_mode_ctrl: RTL
==================

# vga_mode_ctrl

Pattern-mode controller that sits directly upstream of the VGA test-pattern generator and drives its 4-bit display-mode select. It debounces the user push-button, distinguishes short presses (advance pattern) from long presses (toggle auto-cycling), and runs the auto-advance timer. Every mode change is applied only on a frame boundary, so a pattern never switches mid-frame.

## Interface
Parameters:
- NUM_MODES, 14: number of patterns; dis_mode cycles 0..NUM_MODES-1 (max 16).
- DEBOUNCE_CYCLES, 90000: consecutive stable cycles required to accept a key level change.
- LONG_CYCLES, 65000000: debounced hold time that counts as a long press (~1 s at 65 MHz).
- AUTO_CYCLES, 120000000: auto-advance period in vga_clk cycles.
- AUTO_DEFAULT, 1: value of auto_en after reset.

Ports:
- vga_clk  in  1  pixel clock; all logic on rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- key_n  in  1  raw push-button, active-low, asynchronous to vga_clk.
- frame_start  in  1  one-cycle pulse from the timing generator at the first pixel of a frame (line 1, pixel 1).
- dis_mode  out  4  current pattern select to the generator.
- auto_en  out  1  auto-cycling enabled.
- led  out  1  equals auto_en.
- mode_changed  out  1  one-cycle pulse in the cycle after dis_mode takes a new value.

## Operation
- Reset values: dis_mode=0, auto_en=AUTO_DEFAULT, led=AUTO_DEFAULT, mode_changed=0. Internal state resets to: synchronizer=1, debounced key=released, FSM=IDLE, all counters 0, pending=0.
- Synchronizer: two flops on key_n.
- Debounce: the counter increments while the synchronized level differs from the debounced level, and clears when they match. When it reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
- Press FSM:
  - IDLE: on debounced press, go to PRESSED and clear hold_cnt.
  - PRESSED: hold_cnt increments each cycle.
    - If hold_cnt reaches LONG_CYCLES-1: toggle auto_en, clear auto_cnt, go to LONG_HELD.
    - Else on debounced release: raise a manual advance request and go to IDLE.
  - LONG_HELD: on debounced release, go to IDLE with no advance request.
- Auto timer: while auto_en=1, auto_cnt counts 0..AUTO_CYCLES-1. At AUTO_CYCLES-1 it raises an advance request and wraps to 0. While auto_en=0, auto_cnt is held at 0.
  - A manual advance request also clears auto_cnt, so the next automatic step is a full period away.
- Pending flag: set by any advance request. Any number of requests between two frame_start pulses coalesce into a single step.
- Apply: in a cycle where frame_start=1 and (pending=1 or a request is raised that same cycle):
  - dis_mode becomes 0 if dis_mode=NUM_MODES-1, otherwise dis_mode+1.
  - pending clears, and mode_changed asserts on the following cycle.
- A request raised in a cycle where frame_start=0 waits for the next frame_start.
- Counter widths: $clog2 of the corresponding parameter, minimum 1 bit.
- The mode step is a 4-bit compare-and-increment; it never produces a value ≥ NUM_MODES.
- Reset mid-press: all state reinitializes. A key still held when rstn deasserts is seen as a fresh press after the synchronizer plus DEBOUNCE_CYCLES.

## Timing
- key_n edge to debounced edge: 2 synchronizer cycles + DEBOUNCE_CYCLES.
- Debounced release to pending=1: 1 cycle. Debounced release to dis_mode update: the next frame_start edge, at most one frame period.
- dis_mode is registered; it is stable for a whole frame and changes only on a vga_clk edge where frame_start=1.
- auto_en toggles exactly LONG_CYCLES cycles after the debounced press edge, while the key is still held.
- frame_start wider than one cycle is illegal. Only its sampled-high cycle matters, and pending is cleared on the first such cycle.

## Test plan
Use DEBOUNCE_CYCLES=4, LONG_CYCLES=50, AUTO_CYCLES=100, NUM_MODES=14, and frame_start every 30 cycles unless stated.
- Reset: assert rstn=0 mid-run -> dis_mode=0, auto_en=1, led=1, mode_changed=0 immediately (asynchronous).
- Short press, auto_en=0: press 20 cycles, then release -> dis_mode 0→1 at the next frame_start; mode_changed is high exactly one cycle. A 3-cycle glitch on key_n -> no change.
- Long press: hold 60 cycles -> auto_en toggles at debounced press + 50 cycles; release -> dis_mode unchanged.
- Auto cycling with auto_en=1 and no key activity -> dis_mode advances once per 100 cycles, applied on frame boundaries; 0..13 then wraps to 0.
- Coalescing: two short presses within one frame -> a single step (e.g. 5→6), not 5→7.
- Simultaneous events: request raised in the same cycle as frame_start -> applied that cycle. A manual press at auto_cnt=90 -> the next auto step occurs 100 cycles after the press.

Source files
------------

// File: rtl/vga_mode_ctrl.sv
// Pattern-mode controller for the VGA test-pattern generator: debounced push-button
// with short/long press detection, auto-advance timer and frame-aligned mode stepping.
module vga_mode_ctrl #(
    parameter int unsigned NUM_MODES       = 14,
    parameter int unsigned DEBOUNCE_CYCLES = 90000,
    parameter int unsigned LONG_CYCLES     = 65000000,
    parameter int unsigned AUTO_CYCLES     = 120000000,
    parameter bit          AUTO_DEFAULT    = 1'b1
) (
    input  logic       vga_clk,
    input  logic       rstn,
    input  logic       key_n,
    input  logic       frame_start,
    output logic [3:0] dis_mode,
    output logic       auto_en,
    output logic       led,
    output logic       mode_changed
);

    localparam int unsigned DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned HOLD_W = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
    localparam int unsigned AUTO_W = (AUTO_CYCLES > 1) ? $clog2(AUTO_CYCLES) : 1;

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_CYCLES - 1);
    localparam logic [3:0]        MODE_LAST = 4'(NUM_MODES - 1);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_PRESSED   = 2'd1;
    localparam logic [1:0] S_LONG_HELD = 2'd2;

    logic              key_s1;
    logic              key_s2;
    logic              key_db;
    logic [DB_W-1:0]   db_cnt;
    logic              db_flip_c;
    logic              press_c;
    logic              release_c;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_nxt;
    logic              man_req_c;
    logic              toggle_c;

    logic [AUTO_W-1:0] auto_cnt;
    logic              auto_req_c;
    logic              advance_c;
    logic              apply_c;
    logic              pending;

    // Two-flop synchronizer; idles at the released level
    always_ff @(posedge vga_clk or negedge rstn) begin
        if (!rstn) begin
            key_s1 <= 1'b1;
            key_s2 <= 1'b1;
        end else begin
            key_s1 <= key_n;
            key_s2 <= key_s1;
        end
    end

    // Debounce: a level change is accepted after DEBOUNCE_CYCLES consecutive differing samples
    assign db_flip_c = (key_s2 != key_db) && (db_cnt == DB_LAST);
    assign press_c   = db_flip_c & key_db;
    assign release_c = db_flip_c & ~key_db;

    always_ff @(posedge vga_clk or negedge rstn) begin
        if (!rstn) begin
            key_db <= 1'b1;
            db_cnt <= '0;
        end else if (key_s2 == key_db) begin
            db_cnt <= '0;
        end else if (db_flip_c) begin
            key_db <= ~key_db;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end

    // Press FSM state register
    always_ff @(posedge vga_clk or negedge rstn) begin
        if (!rstn) begin
            state    <= S_IDLE;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    // Press FSM next-state; a long hold takes priority over a release in the same cycle
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        man_req_c = 1'b0;
        toggle_c  = 1'b0;
        case (state)
            S_IDLE: begin
                if (press_c) begin
                    state_nxt = S_PRESSED;
                    hold_nxt  = '0;
                end
            end
            S_PRESSED: begin
                hold_nxt = hold_cnt + HOLD_W'(1);
                if (hold_cnt == HOLD_LAST) begin
                    toggle_c  = 1'b1;
                    state_nxt = S_LONG_HELD;
                end else if (release_c) begin
                    man_req_c = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_LONG_HELD: begin
                if (key_db) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Auto-advance timer; any manual step or toggle restarts a full period
    assign auto_req_c = auto_en && (auto_cnt == AUTO_LAST);

    always_ff @(posedge vga_clk or negedge rstn) begin
        if (!rstn) begin
            auto_en  <= AUTO_DEFAULT;
            auto_cnt <= '0;
        end else begin
            if (toggle_c) begin
                auto_en <= ~auto_en;
            end
            if (!auto_en || toggle_c || man_req_c || auto_req_c) begin
                auto_cnt <= '0;
            end else begin
                auto_cnt <= auto_cnt + AUTO_W'(1);
            end
        end
    end

    assign led = auto_en;

    // Requests coalesce in pending and are applied only on a frame_start cycle
    assign advance_c = man_req_c | auto_req_c;
    assign apply_c   = frame_start & (pending | advance_c);

    always_ff @(posedge vga_clk or negedge rstn) begin
        if (!rstn) begin
            dis_mode     <= 4'd0;
            pending      <= 1'b0;
            mode_changed <= 1'b0;
        end else begin
            mode_changed <= apply_c;
            if (apply_c) begin
                dis_mode <= (dis_mode >= MODE_LAST) ? 4'd0 : dis_mode + 4'd1;
                pending  <= 1'b0;
            end else if (advance_c) begin
                pending <= 1'b1;
            end
        end
    end

endmodule
